datapath_sequencer: RTL and testbench
=====================================

DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 Parameter DEPTH, default 8; instruction-queue depth in entries (power of two).
REQ-002 Parameter NOP_OP, default 16'h0FDF; idle opcode (move r15 -> r15) driven whenever no instruction issues.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 start  input  1  reset; asynchronous, active-low.
REQ-005 instr_in  input  16  instruction word from host.
REQ-006 instr_valid  input  1  host offers instr_in this cycle.
REQ-007 instr_ready  output  1  queue can accept; combinational, high when fifo_count < DEPTH.
REQ-008 run  input  1  level; high = issue continuously.
REQ-009 step  input  1  single-cycle pulse; issue exactly one instruction.
REQ-010 flush  input  1  synchronous queue clear.
REQ-011 flags_in  input  5  flag vector returned by the datapath for the opcode currently driven.
REQ-012 opCode  output  16  registered opcode to the datapath.
REQ-013 issue  output  1  registered; high when opCode holds a queued instruction, not NOP_OP.
REQ-014 cin  output  1  registered carry-in to the datapath.
REQ-015 flags_out  output  5  registered copy of last captured flags.
REQ-016 fifo_count  output  $clog2(DEPTH)+1  entries held.
REQ-017 issue_count  output  8  instructions issued since reset; wraps.
REQ-018 halted  output  1  high in state HALT.

Function
REQ-019 Push: instr_valid & instr_ready at a rising edge writes instr_in at the tail; no write when instr_ready is low, and no existing entry is overwritten.
REQ-020 Pop: an edge with state RUN or STEP and fifo_count > 0 loads the head into opCode, sets issue=1, advances the head, and increments issue_count (255 -> 0).
REQ-021 Any other edge loads opCode=NOP_OP and issue=0.
REQ-022 Push and pop on the same edge leave fifo_count unchanged.
REQ-023 No bypass: a word pushed into an empty queue issues no earlier than the following edge.
REQ-024 Queue pointers wrap modulo DEPTH.
REQ-025 FSM states: IDLE, RUN, STEP, HALT.
REQ-026 IDLE -> STEP if step; otherwise IDLE -> RUN if run and fifo_count > 0; otherwise stay.
REQ-027 RUN: issue every cycle; -> HALT when run=0; -> IDLE when the last entry pops with no simultaneous push.
REQ-028 STEP: issue one instruction (or none if empty), then -> HALT unconditionally; lasts one cycle.
REQ-029 HALT: -> STEP if step; otherwise -> RUN if run and fifo_count > 0; otherwise -> IDLE if run and queue empty; otherwise stay.
REQ-030 step has priority over run in IDLE and HALT.
REQ-031 Flag capture: on every edge where issue=1, flags_out <= flags_in and cin <= flags_in[3]; both hold when issue=0.
REQ-032 flush: empties the queue, sets state IDLE, opCode=NOP_OP, issue=0; has priority over push, pop and step.
REQ-033 flush does not alter issue_count, cin or flags_out.

Reset
REQ-034 start=0 asynchronously sets opCode=NOP_OP, issue=0, cin=0, flags_out=0, issue_count=0, fifo_count=0, pointers=0, state IDLE, halted=0, regardless of clk.
REQ-035 Reset mid-run discards all queued instructions; after start returns high, the first instruction issues only after a new push and run or step.

Verification
REQ-036 Reset: start=0 -> opCode=16'h0FDF, issue=0, cin=0, fifo_count=0, instr_ready=1, issue_count=0.
REQ-037 Ordered run: push 16'h5001, 16'h5101, 16'h0150 with run=0; raise run -> opCode shows those three on three consecutive edges with issue=1, then 16'h0FDF with issue=0; state IDLE; issue_count=3.
REQ-038 Full queue: hold instr_valid for 9 pushes 16'h0001..16'h0009, run=0 -> fifo_count=8, instr_ready=0 at the 9th; drain yields 0001..0008 only.
REQ-039 Step and halt: queue two entries; pulse step -> one issue, halted=1, fifo_count=1; run=1 then issues the remaining entry.
REQ-040 Carry path: flags_in=5'b01000 while issue=1 -> cin=1 and flags_out=5'b01000 after the edge; flags_in=5'b00000 while issue=0 -> cin stays 1.
REQ-041 Simultaneous events: push during RUN at fifo_count=1 -> count stays 1 and no IDLE exit; flush with step and push on one edge -> queue empty, IDLE, no issue.

Source files
------------

// File: rtl/datapath_sequencer.sv
// datapath_sequencer
//   Holds host instructions in a small circular queue and issues them to the
//   datapath one per clock, either continuously (run) or one at a time (step).
//   While nothing issues the idle opcode NOP_OP is driven. The flag vector
//   returned for each issued opcode is captured, and its carry bit feeds cin.
//
// Ports
//   clk          single clock, rising edge
//   start        asynchronous active-low reset
//   instr_in     instruction word from host
//   instr_valid  host offers instr_in this cycle
//   instr_ready  queue has room (fifo_count < DEPTH)
//   run          level: issue continuously
//   step         one-cycle pulse: issue exactly one instruction
//   flush        synchronous queue clear, returns the sequencer to IDLE
//   flags_in     flags returned by the datapath for the opcode now driven
//   opCode       registered opcode to the datapath
//   issue        opCode holds a queued instruction (not NOP_OP)
//   cin          registered carry-in (flags bit 3 of last captured flags)
//   flags_out    last captured flags
//   fifo_count   entries held in the queue
//   issue_count  instructions issued since reset, wraps at 256
//   halted       sequencer is in HALT
module datapath_sequencer #(
  parameter int          DEPTH  = 8,
  parameter logic [15:0] NOP_OP = 16'h0FDF
) (
  input  logic                   clk,
  input  logic                   start,
  input  logic [15:0]            instr_in,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic                   run,
  input  logic                   step,
  input  logic                   flush,
  input  logic [4:0]             flags_in,
  output logic [15:0]            opCode,
  output logic                   issue,
  output logic                   cin,
  output logic [4:0]             flags_out,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             issue_count,
  output logic                   halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} state_t;

  state_t         state_q, state_d;
  logic [15:0]    mem_q [DEPTH];
  logic [AW-1:0]  head_q, head_d;
  logic [AW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic [15:0]    opcode_q, opcode_d;
  logic           issue_q, issue_d;
  logic           cin_q, cin_d;
  logic [4:0]     flags_q, flags_d;
  logic [7:0]     icnt_q, icnt_d;
  logic           push, pop;

  assign instr_ready = (count_q < FULL);

  // Next-state: queue handshake, issue decision, flag capture and FSM
  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    opcode_d = NOP_OP;
    issue_d  = 1'b0;
    cin_d    = cin_q;
    flags_d  = flags_q;
    icnt_d   = icnt_q;

    // Pop looks only at the registered count, so a word written this edge
    // can never be issued on the same edge.
    push = instr_valid && instr_ready && !flush;
    pop  = ((state_q == RUN) || (state_q == STEP)) && (count_q != '0) && !flush;

    // Flags belong to the opcode currently on the bus, so capture follows
    // the registered issue bit rather than this edge's pop.
    if (issue_q) begin
      flags_d = flags_in;
      cin_d   = flags_in[3];
    end

    if (pop) begin
      opcode_d = mem_q[head_q];
      issue_d  = 1'b1;
      head_d   = head_q + AW'(1);
      icnt_d   = icnt_q + 8'd1;
    end

    if (push) begin
      tail_d = tail_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (step)                          state_d = STEP;
          else if (run && (count_q != '0))   state_d = RUN;
        end
        RUN: begin
          if (!run)                          state_d = HALT;
          else if (count_d == '0)            state_d = IDLE;
        end
        STEP:                                state_d = HALT;
        HALT: begin
          if (step)                          state_d = STEP;
          else if (run && (count_q != '0))   state_d = RUN;
          else if (run)                      state_d = IDLE;
        end
        default:                             state_d = IDLE;
      endcase
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_q  <= IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      opcode_q <= NOP_OP;
      issue_q  <= 1'b0;
      cin_q    <= 1'b0;
      flags_q  <= '0;
      icnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      opcode_q <= opcode_d;
      issue_q  <= issue_d;
      cin_q    <= cin_d;
      flags_q  <= flags_d;
      icnt_q   <= icnt_d;
    end
  end

  // Queue storage: data only, never reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= instr_in;
    end
  end

  assign opCode      = opcode_q;
  assign issue       = issue_q;
  assign cin         = cin_q;
  assign flags_out   = flags_q;
  assign fifo_count  = count_q;
  assign issue_count = icnt_q;
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_datapath_sequencer.sv
module tb_datapath_sequencer;

  localparam int          DEPTH = 8;
  localparam logic [15:0] NOP   = 16'h0FDF;

  logic        clk = 1'b0;
  logic        start;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic        run;
  logic        step;
  logic        flush;
  logic [4:0]  flags_in;
  logic [15:0] opCode;
  logic        issue;
  logic        cin;
  logic [4:0]  flags_out;
  logic [3:0]  fifo_count;
  logic [7:0]  issue_count;
  logic        halted;

  datapath_sequencer #(.DEPTH(DEPTH), .NOP_OP(NOP)) dut (
    .clk(clk), .start(start), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .run(run), .step(step), .flush(flush),
    .flags_in(flags_in), .opCode(opCode), .issue(issue), .cin(cin),
    .flags_out(flags_out), .fifo_count(fifo_count), .issue_count(issue_count),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Expected post-edge view of every output
  typedef struct {
    logic [15:0] op;
    logic        iss;
    logic        c;
    logic [4:0]  fl;
    int          cnt;
    int          icnt;
    logic        hlt;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  logic [15:0] dut_iss[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: a queue of words plus the four-state sequencer
  typedef enum {M_IDLE, M_RUN, M_STEP, M_HALT} mstate_t;
  mstate_t     ms;
  logic [15:0] mq[$];
  logic [15:0] m_op;
  logic        m_iss;
  logic        m_cin;
  logic [4:0]  m_fl;
  int          m_icnt;

  task automatic model_reset();
    ms = M_IDLE; mq.delete(); m_op = NOP; m_iss = 1'b0;
    m_cin = 1'b0; m_fl = '0; m_icnt = 0;
  endtask

  task automatic model_step(input logic v, input logic [15:0] d, input logic r,
                            input logic s, input logic f, input logic [4:0] fl);
    int   pre;
    logic pu;
    logic po;
    exp_t e;
    pre = mq.size();
    pu  = v && (pre < DEPTH) && !f;
    po  = (ms == M_RUN || ms == M_STEP) && (pre > 0) && !f;
    if (m_iss) begin
      m_fl  = fl;
      m_cin = fl[3];
    end
    if (po) begin
      m_op   = mq.pop_front();
      m_iss  = 1'b1;
      m_icnt = (m_icnt + 1) % 256;
    end else begin
      m_op  = NOP;
      m_iss = 1'b0;
    end
    if (pu) mq.push_back(d);
    if (f) begin
      mq.delete();
      ms = M_IDLE;
    end else begin
      case (ms)
        M_IDLE: if (s) ms = M_STEP; else if (r && pre > 0) ms = M_RUN;
        M_RUN:  if (!r) ms = M_HALT; else if (mq.size() == 0) ms = M_IDLE;
        M_STEP: ms = M_HALT;
        M_HALT: if (s) ms = M_STEP; else if (r && pre > 0) ms = M_RUN;
                else if (r) ms = M_IDLE;
        default: ms = M_IDLE;
      endcase
    end
    e.op = m_op; e.iss = m_iss; e.c = m_cin; e.fl = m_fl;
    e.cnt = mq.size(); e.icnt = m_icnt; e.hlt = (ms == M_HALT);
    e.rdy = (mq.size() < DEPTH);
    exp_q.push_back(e);
  endtask

  // Drive one edge worth of inputs and queue the expected result
  task automatic cycle(input logic v, input logic [15:0] d, input logic r,
                       input logic s, input logic f, input logic [4:0] fl);
    @(negedge clk);
    instr_valid = v; instr_in = d; run = r; step = s; flush = f; flags_in = fl;
    model_step(v, d, r, s, f, fl);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_list(input string name, input logic [15:0] want[$]);
    chk({name, "_len"}, dut_iss.size(), want.size());
    for (int i = 0; i < want.size() && i < dut_iss.size(); i++)
      chk(name, dut_iss[i], want[i]);
  endtask

  // Monitor: compare every presented output against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (issue === 1'b1) dut_iss.push_back(opCode);
        chk("opCode",      opCode,      e.op);
        chk("issue",       issue,       e.iss);
        chk("cin",         cin,         e.c);
        chk("flags_out",   flags_out,   e.fl);
        chk("fifo_count",  fifo_count,  e.cnt);
        chk("issue_count", issue_count, e.icnt);
        chk("halted",      halted,      e.hlt);
        chk("instr_ready", instr_ready, e.rdy);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, dut=running expected=done");
    $fatal(1);
  end

  initial begin
    logic       run_lvl;
    logic [15:0] want[$];
    start = 1'b0; instr_in = '0; instr_valid = 1'b0; run = 1'b0;
    step = 1'b0; flush = 1'b0; flags_in = '0;
    model_reset();
    #12;
    chk("rst_opCode", opCode, 16'h0FDF);
    chk("rst_issue", issue, 0);
    chk("rst_cin", cin, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_instr_ready", instr_ready, 1);
    chk("rst_issue_count", issue_count, 0);
    chk("rst_halted", halted, 0);
    @(negedge clk);
    start = 1'b1;

    // Ordered run
    dut_iss.delete();
    cycle(1, 16'h5001, 0, 0, 0, 0);
    cycle(1, 16'h5101, 0, 0, 0, 0);
    cycle(1, 16'h0150, 0, 0, 0, 0);
    repeat (5) cycle(0, 0, 1, 0, 0, 0);
    settle();
    want = '{16'h5001, 16'h5101, 16'h0150};
    chk_list("ordered_run", want);
    chk("ordered_issue_count", issue_count, 3);
    chk("ordered_idle_op", opCode, 16'h0FDF);

    // Full queue
    dut_iss.delete();
    for (int i = 1; i <= 9; i++) cycle(1, 16'(i), 0, 0, 0, 0);
    settle();
    chk("full_count", fifo_count, 8);
    chk("full_ready", instr_ready, 0);
    repeat (10) cycle(0, 0, 1, 0, 0, 0);
    settle();
    want = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
    chk_list("full_drain", want);

    // Step and halt
    dut_iss.delete();
    cycle(1, 16'hA001, 0, 0, 0, 0);
    cycle(1, 16'hA002, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    settle();
    chk("step_halted", halted, 1);
    chk("step_count", fifo_count, 1);
    repeat (3) cycle(0, 0, 1, 0, 0, 0);
    settle();
    want = '{16'hA001, 16'hA002};
    chk_list("step_then_run", want);

    // Carry path
    cycle(1, 16'hC001, 0, 0, 0, 5'b00000);
    cycle(0, 0, 1, 0, 0, 5'b00000);
    cycle(0, 0, 1, 0, 0, 5'b00000);
    cycle(0, 0, 1, 0, 0, 5'b01000);
    settle();
    chk("carry_cin", cin, 1);
    chk("carry_flags", flags_out, 5'b01000);
    cycle(0, 0, 0, 0, 0, 5'b00000);
    settle();
    chk("carry_hold", cin, 1);

    // Push during RUN at count 1, then flush colliding with step and push
    cycle(1, 16'hB001, 0, 0, 0, 0);
    cycle(1, 16'hB002, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(1, 16'hB003, 1, 0, 0, 0);
    settle();
    chk("simul_count", fifo_count, 1);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 16'hD001, 0, 0, 0, 0);
    cycle(1, 16'hD002, 0, 0, 0, 0);
    cycle(1, 16'hD003, 0, 1, 1, 0);
    settle();
    chk("flush_count", fifo_count, 0);
    chk("flush_issue", issue, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Asynchronous reset with work queued
    cycle(1, 16'hE001, 0, 0, 0, 0);
    cycle(1, 16'hE002, 0, 0, 0, 0);
    cycle(1, 16'hE003, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    settle();
    start = 1'b0;
    #1;
    chk("arst_opCode", opCode, 16'h0FDF);
    chk("arst_fifo_count", fifo_count, 0);
    chk("arst_issue_count", issue_count, 0);
    chk("arst_issue", issue, 0);
    model_reset();
    instr_valid = 1'b0; run = 1'b0; step = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    repeat (3) cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0, 0);

    // Randomized traffic
    run_lvl = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) run_lvl = ~run_lvl;
      cycle($urandom_range(1), 16'($urandom), run_lvl,
            ($urandom_range(9) == 0), ($urandom_range(29) == 0), 5'($urandom));
    end
    settle();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
